// File: rtl/ff_bank_multimode.sv
// ff_bank_multimode: a bank of WIDTH flip-flops that behaves as SR, JK, D or T
// flops, selected per clock edge by 'mode'. It also flags SR S=R=1 conditions
// with a sticky error bit and a saturating counter, and reports whether the
// last enabled edge changed any bit.
module ff_bank_multimode #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SR11_POL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             chg
);

    localparam logic [1:0] ModeSr = 2'b00;
    localparam logic [1:0] ModeJk = 2'b01;
    localparam logic [1:0] ModeD  = 2'b10;
    localparam logic [1:0] ModeT  = 2'b11;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d, q_next;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             err_base;
    logic             invalid;

    // Per-bit next state for the selected flip-flop personality.
    always_comb begin
        q_next = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode)
                ModeSr: begin
                    unique case ({a[i], b[i]})
                        2'b00: q_next[i] = q_q[i];
                        2'b10: q_next[i] = 1'b1;
                        2'b01: q_next[i] = 1'b0;
                        2'b11: begin
                            if (SR11_POL == 1) begin
                                q_next[i] = 1'b1;
                            end else if (SR11_POL == 2) begin
                                q_next[i] = 1'b0;
                            end else begin
                                q_next[i] = q_q[i];
                            end
                        end
                        default: q_next[i] = q_q[i];
                    endcase
                end
                ModeJk: begin
                    unique case ({a[i], b[i]})
                        2'b00: q_next[i] = q_q[i];
                        2'b10: q_next[i] = 1'b1;
                        2'b01: q_next[i] = 1'b0;
                        2'b11: q_next[i] = ~q_q[i];
                        default: q_next[i] = q_q[i];
                    endcase
                end
                ModeD: q_next[i] = a[i];
                ModeT: q_next[i] = q_q[i] ^ a[i];
                default: q_next[i] = q_q[i];
            endcase
        end
    end

    // Bank update, change flag and error bookkeeping.
    always_comb begin
        invalid = en && (mode == ModeSr) && (|(a & b));

        q_d   = en ? q_next : q_q;
        // chg reports only enabled edges; a disabled edge reads as "no change".
        chg_d = en ? |(q_next ^ q_q) : 1'b0;

        // Clear first, then count, so clear plus an invalid edge yields 1.
        err_base = clr_err ? 1'b0 : err_q;
        cnt_base = clr_err ? '0 : cnt_q;
        err_d    = err_base;
        cnt_d    = cnt_base;
        if (invalid) begin
            err_d = 1'b1;
            cnt_d = (cnt_base == CntMax) ? cnt_base : cnt_base + 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            chg_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;
    assign chg     = chg_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Testbench for ff_bank_multimode: three instances with different SR11_POL /
// CNT_W settings share stimulus and are compared to a word-level model.
module tb_ff_bank_multimode;

    localparam logic [1:0] SR = 2'b00, JK = 2'b01, DM = 2'b10, TM = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       clr_err = 1'b0;

    logic [7:0] dq [3];
    logic [7:0] dqn [3];
    logic       derr [3];
    logic       dchg [3];
    logic [7:0] dcnt0;
    logic [1:0] dcnt1;
    logic [2:0] dcnt2;

    int errors = 0;
    int checks = 0;

    // Model state per instance
    logic [7:0] m_q [3];
    logic       m_err [3];
    logic       m_chg [3];
    int         m_cnt [3];
    int         pol [3];
    int         cmax [3];

    always #5 clk = ~clk;

    ff_bank_multimode #(.WIDTH(8), .CNT_W(8), .SR11_POL(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(dq[0]), .qn(dqn[0]), .err(derr[0]), .err_cnt(dcnt0), .chg(dchg[0])
    );
    ff_bank_multimode #(.WIDTH(8), .CNT_W(2), .SR11_POL(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(dq[1]), .qn(dqn[1]), .err(derr[1]), .err_cnt(dcnt1), .chg(dchg[1])
    );
    ff_bank_multimode #(.WIDTH(8), .CNT_W(3), .SR11_POL(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(dq[2]), .qn(dqn[2]), .err(derr[2]), .err_cnt(dcnt2), .chg(dchg[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int k);
        if (k == 0) return {24'd0, dcnt0};
        if (k == 1) return {30'd0, dcnt1};
        return {29'd0, dcnt2};
    endfunction

    // Word-level next state from the flip-flop characteristic rules.
    function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] qv,
                                              input logic [7:0] av, input logic [7:0] bv,
                                              input int p);
        logic [7:0] set_m, clr_m, both, base;
        case (m)
            SR: begin
                set_m = av & ~bv;
                clr_m = ~av & bv;
                both  = av & bv;
                base  = (qv | set_m) & ~clr_m;
                if (p == 1) return base | both;
                if (p == 2) return base & ~both;
                return base;
            end
            JK:      return (av & ~qv) | (~bv & qv);
            DM:      return av;
            default: return qv ^ av;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 8'h00; m_err[k] = 1'b0; m_chg[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(input logic e, input logic [1:0] m, input logic [7:0] av,
                              input logic [7:0] bv, input logic c);
        logic [7:0] nq;
        logic       inv;
        inv = e && (m == SR) && ((av & bv) != 8'h00);
        for (int k = 0; k < 3; k++) begin
            nq = model_next(m, m_q[k], av, bv, pol[k]);
            if (e) begin
                m_chg[k] = (nq != m_q[k]);
                m_q[k]   = nq;
            end else begin
                m_chg[k] = 1'b0;
            end
            if (c) begin
                m_err[k] = 1'b0;
                m_cnt[k] = 0;
            end
            if (inv) begin
                m_err[k] = 1'b1;
                if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s_q%0d", ph, k), {24'd0, dq[k]}, {24'd0, m_q[k]});
            check_eq($sformatf("%s_qn%0d", ph, k), {24'd0, dqn[k]}, {24'd0, ~m_q[k]});
            check_eq($sformatf("%s_err%0d", ph, k), {31'd0, derr[k]}, {31'd0, m_err[k]});
            check_eq($sformatf("%s_cnt%0d", ph, k), get_cnt(k), m_cnt[k]);
            check_eq($sformatf("%s_chg%0d", ph, k), {31'd0, dchg[k]}, {31'd0, m_chg[k]});
        end
    endtask

    // Drive one edge's inputs, clock it, and compare #1 after the edge.
    task automatic step(input string ph, input logic e, input logic [1:0] m,
                        input logic [7:0] av, input logic [7:0] bv, input logic c);
        en = e; mode = m; a = av; b = bv; clr_err = c;
        @(posedge clk);
        model_edge(e, m, av, bv, c);
        #1;
        check_all(ph);
    endtask

    // Called #1 after an edge: pulse reset mid-cycle, hold it across an edge.
    task automatic do_reset(input string ph);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({ph, "_async"});
        en = 1'b1; mode = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
        clr_err = 1'b0;
        @(posedge clk);
        #1;
        check_all({ph, "_held"});
        #3;
        rst = 1'b0;
    endtask

    initial begin
        pol[0] = 0; pol[1] = 1; pol[2] = 2;
        cmax[0] = 255; cmax[1] = 3; cmax[2] = 7;
        model_reset();

        #1 rst = 1'b1;
        #1;
        check_all("rst0");
        #12 rst = 1'b0;  // released at t=14, between edges
        @(posedge clk); #1;
        check_all("idle");

        // D mode basic and repeated input
        step("d1", 1'b1, DM, 8'hA5, 8'h00, 1'b0);
        check_eq("d1_q", {24'd0, dq[0]}, 32'hA5);
        check_eq("d1_qn", {24'd0, dqn[0]}, 32'h5A);
        check_eq("d1_chg", {31'd0, dchg[0]}, 32'd1);
        step("d2", 1'b1, DM, 8'hA5, 8'h00, 1'b0);
        check_eq("d2_chg", {31'd0, dchg[0]}, 32'd0);

        // SR set / clear
        step("d0", 1'b1, DM, 8'h00, 8'h00, 1'b0);
        step("sr1", 1'b1, SR, 8'h0F, 8'h00, 1'b0);
        check_eq("sr1_q", {24'd0, dq[0]}, 32'h0F);
        step("sr2", 1'b1, SR, 8'h00, 8'h03, 1'b0);
        check_eq("sr2_q", {24'd0, dq[0]}, 32'h0C);
        check_eq("sr2_err", {31'd0, derr[0]}, 32'd0);

        // SR invalid edges, then clear coinciding with an invalid edge
        for (int i = 0; i < 3; i++) step("inv", 1'b1, SR, 8'hFF, 8'hFF, 1'b0);
        check_eq("inv_q", {24'd0, dq[0]}, 32'h0C);
        check_eq("inv_err", {31'd0, derr[0]}, 32'd1);
        check_eq("inv_cnt", get_cnt(0), 32'd3);
        step("clrinv", 1'b1, SR, 8'hFF, 8'hFF, 1'b1);
        check_eq("clrinv_cnt", get_cnt(0), 32'd1);
        check_eq("clrinv_err", {31'd0, derr[0]}, 32'd1);
        for (int i = 0; i < 4; i++) step("sat", 1'b1, SR, 8'h81, 8'h01, 1'b0);
        check_eq("sat_cnt1", get_cnt(1), 32'd3);
        check_eq("sat_err1", {31'd0, derr[1]}, 32'd1);

        // clr_err while disabled
        step("clr_dis", 1'b0, SR, 8'hFF, 8'hFF, 1'b1);
        check_eq("clr_dis_cnt", get_cnt(0), 32'd0);

        // JK toggle and disabled T edge
        step("jk0", 1'b1, DM, 8'h3C, 8'h00, 1'b0);
        step("jk1", 1'b1, JK, 8'hFF, 8'hFF, 1'b0);
        check_eq("jk1_q", {24'd0, dq[0]}, 32'hC3);
        step("jk2", 1'b1, JK, 8'hFF, 8'hFF, 1'b0);
        check_eq("jk2_q", {24'd0, dq[0]}, 32'h3C);
        step("tdis", 1'b0, TM, 8'h01, 8'h00, 1'b0);
        check_eq("tdis_q", {24'd0, dq[0]}, 32'h3C);
        check_eq("tdis_chg", {31'd0, dchg[0]}, 32'd0);
        step("ten", 1'b1, TM, 8'h01, 8'h00, 1'b0);

        // Mid-cycle reset with q=FF, err_cnt=2
        step("pr0", 1'b1, DM, 8'hFF, 8'h00, 1'b0);
        step("pr1", 1'b1, SR, 8'hFF, 8'hFF, 1'b1);
        step("pr2", 1'b1, SR, 8'hFF, 8'hFF, 1'b0);
        check_eq("pr2_cnt", get_cnt(0), 32'd2);
        do_reset("mrst");
        check_eq("mrst_q", {24'd0, dq[0]}, 32'h00);
        check_eq("mrst_qn", {24'd0, dqn[0]}, 32'hFF);
        check_eq("mrst_cnt", get_cnt(0), 32'd0);
        step("post", 1'b1, DM, 8'h5A, 8'h00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       e, c;
            logic [1:0] m;
            logic [7:0] av, bv;
            e  = ($urandom_range(0, 99) < 85);
            c  = ($urandom_range(0, 99) < 8);
            m  = 2'($urandom_range(0, 3));
            av = 8'($urandom);
            bv = 8'($urandom);
            if ($urandom_range(0, 1) == 1) bv = bv & ~av;
            step("rnd", e, m, av, bv, c);
            if ($urandom_range(0, 99) < 2) do_reset("rrst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
